// File: rtl/number_render.sv
// Four-digit BCD number overlay renderer for a scanned display.
// Looks up 10x10 glyphs in an external synchronous ROM and keys out KEY_COLOR.
// Three-stage pipeline: address -> ROM data alignment -> keyed output.
// Optional feature: define NUMBER_RENDER_LZB_EN for leading-zero blanking.
module number_render #(
    parameter int unsigned           DATA_WIDTH = 12,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'h0F0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pix_valid,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic                  frame_start,
    input  logic [15:0]           value,
    input  logic [9:0]            pos_x,
    input  logic [9:0]            pos_y,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] rgb_o,
    output logic                  hit_o,
    output logic                  valid_o
);

    logic [15:0] value_q;
    logic [9:0]  pos_x_q;
    logic [9:0]  pos_y_q;
    logic        armed_q;   // set by the first frame_start after reset

    logic        in_box_q;
    logic        valid1_q;
    logic        in_box2_q;
    logic        valid2_q;

    logic        in_x;
    logic        in_y;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [1:0]  slot;
    logic [3:0]  col;
    logic [3:0]  digit;
    logic        lz_blank;
    logic        hit1;
    logic [9:0]  addr_calc;
    logic        hit3;

    // Shadow copies of the number and position, refreshed only on frame_start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            armed_q <= 1'b0;
        end else if (frame_start) begin
            value_q <= value;
            pos_x_q <= pos_x;
            pos_y_q <= pos_y;
            armed_q <= 1'b1;
        end
    end

    // Box test in 11 bits so pos+width near the right/bottom edge cannot wrap
    assign in_x = ({1'b0, pixel_x} >= {1'b0, pos_x_q}) &&
                  ({1'b0, pixel_x} <  ({1'b0, pos_x_q} + 11'd40));
    assign in_y = ({1'b0, pixel_y} >= {1'b0, pos_y_q}) &&
                  ({1'b0, pixel_y} <  ({1'b0, pos_y_q} + 11'd10));
    assign dx   = pixel_x - pos_x_q;
    assign dy   = pixel_y - pos_y_q;

    // Split the box offset into digit slot and glyph column without a divider
    always_comb begin
        slot = 2'd0;
        col  = dx[3:0];
        if (dx < 10'd10) begin
            slot = 2'd0;
            col  = dx[3:0];
        end else if (dx < 10'd20) begin
            slot = 2'd1;
            col  = 4'(dx - 10'd10);
        end else if (dx < 10'd30) begin
            slot = 2'd2;
            col  = 4'(dx - 10'd20);
        end else begin
            slot = 2'd3;
            col  = 4'(dx - 10'd30);
        end
    end

    // Pick the BCD nibble for the slot; slot 0 is the leftmost digit
    always_comb begin
        digit = value_q[3:0];
        unique case (slot)
            2'd0: digit = value_q[15:12];
            2'd1: digit = value_q[11:8];
            2'd2: digit = value_q[7:4];
            2'd3: digit = value_q[3:0];
            default: digit = value_q[3:0];
        endcase
    end

`ifdef NUMBER_RENDER_LZB_EN
    // A slot is blank when it and every digit to its left are zero
    assign lz_blank = ((slot == 2'd0) && (value_q[15:12] == 4'd0)) ||
                      ((slot == 2'd1) && (value_q[15:8]  == 8'd0)) ||
                      ((slot == 2'd2) && (value_q[15:4]  == 12'd0));
`else
    assign lz_blank = 1'b0;
`endif

    assign hit1 = pix_valid && armed_q && in_x && in_y && (digit <= 4'd9) && !lz_blank;
    assign addr_calc = (10'(digit) * 10'd100) + (10'(dy[3:0]) * 10'd10) + 10'(col);

    // Stage 1: ROM address and in-box flag; address holds when nothing to draw
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            in_box_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            in_box_q <= hit1;
            valid1_q <= pix_valid;
            if (hit1) begin
                rom_addr <= ADDR_WIDTH'(addr_calc);
            end
        end
    end

    // Stage 2: delay flags to line up with the synchronous ROM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box2_q <= 1'b0;
            valid2_q  <= 1'b0;
        end else begin
            in_box2_q <= in_box_q;
            valid2_q  <= valid1_q;
        end
    end

    assign hit3 = in_box2_q && (rom_data != KEY_COLOR);

    // Stage 3: keyed colour output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_o <= 1'b0;
            hit_o   <= 1'b0;
            rgb_o   <= '0;
        end else begin
            valid_o <= valid2_q;
            hit_o   <= hit3;
            rgb_o   <= hit3 ? rom_data : '0;
        end
    end

endmodule

// File: doc/number_render.md
NUMBER_RENDER -- requirements
Module: number_render

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 12, as the ROM word / pixel colour width (4:4:4 RGB).
REQ-002 The module SHALL take parameter ADDR_WIDTH, default 10, as the ROM address width.
REQ-003 The module SHALL take parameter KEY_COLOR, default 12'h0F0, as the transparent glyph colour.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pix_valid  input  1  pixel_x/pixel_y qualify this cycle.
REQ-007 pixel_x, pixel_y  input  10 each  current scan coordinate.
REQ-008 frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-009 value  input  16  four BCD digits; [15:12] is the leftmost digit.
REQ-010 pos_x, pos_y  input  10 each  top-left corner of the 40x10 number box.
REQ-011 rom_addr  output  ADDR_WIDTH  registered address to the glyph ROM.
REQ-012 rom_data  input  DATA_WIDTH  glyph ROM data, valid one clk after rom_addr.
REQ-013 rgb_o  output  DATA_WIDTH  glyph pixel colour.
REQ-014 hit_o  output  1  rgb_o is an opaque glyph pixel.
REQ-015 valid_o  output  1  rgb_o/hit_o qualify this cycle.

Function
REQ-016 The module SHALL latch value, pos_x and pos_y into shadow registers only on frame_start; all rendering SHALL use the shadow copies, so mid-frame changes never tear.
REQ-017 Glyph layout SHALL be 10 digits x 10 rows x 10 columns, with address = digit*100 + row*10 + col (0..999).
REQ-018 Stage 1 (cycle N): when pix_valid=1 and pos_x <= pixel_x < pos_x+40 and pos_y <= pixel_y < pos_y+10, the module SHALL set dx=pixel_x-pos_x, slot=dx/10, col=dx%10, row=pixel_y-pos_y, and register rom_addr plus in_box=1 at edge N.
REQ-019 Box bounds SHALL be computed with 11-bit arithmetic so that pos_x+40 or pos_y+10 beyond 1023 never wraps.
REQ-020 A digit nibble greater than 9 SHALL be treated as blank: in_box=0, and rom_addr holds its previous value.
REQ-021 Outside the box, or when pix_valid=0, in_box SHALL be 0 and rom_addr SHALL hold its previous value.
REQ-022 Stage 2 (cycle N+1): in_box and pix_valid SHALL be delayed one cycle to align with rom_data.
REQ-023 Stage 3 (edge N+2): the module SHALL register valid_o = delayed pix_valid.
REQ-024 At the same edge it SHALL register hit_o = delayed in_box AND (rom_data != KEY_COLOR).
REQ-025 At the same edge it SHALL register rgb_o = rom_data when hit_o=1, else 0.
REQ-026 Total latency from pix_valid to valid_o SHALL be exactly 3 clk cycles, fully pipelined at one pixel per cycle with no stalls.
REQ-027 frame_start coincident with pix_valid SHALL apply the new shadow values from the next cycle; the coincident pixel SHALL use the old values.

Reset
REQ-028 While reset_n=0, rom_addr, rgb_o, hit_o, valid_o, all pipeline flags and all shadow registers SHALL be 0.
REQ-029 Assertion of reset_n mid-frame SHALL flush in-flight pixels, with no valid_o after release until new pix_valid input.
REQ-030 After reset release, nothing SHALL render until the first frame_start (shadow value=0, pos=0 would otherwise show "0000" at the origin).

Configuration
REQ-031 With macro NUMBER_RENDER_LZB_EN defined, leading-zero blanking SHALL apply: any 0 digit left of the first nonzero digit SHALL be blank (in_box=0); the rightmost digit SHALL always render.
REQ-032 With NUMBER_RENDER_LZB_EN undefined, all four digits SHALL render, including leading zeros.

Verification
REQ-033 Latency: shadow value=16'h1234, pos=(100,50); pix (100,50) at cycle N -> rom_addr=100 at N+1, valid_o=1 at N+3.
REQ-034 Addressing: pix (137,59) -> rom_addr=4*100+9*10+7=497; pix (140,50) and (99,50) -> hit_o=0, valid_o=1.
REQ-035 Keying: rom_data=12'h0F0 at an in-box pixel -> hit_o=0, rgb_o=0; rom_data=12'hFFF -> hit_o=1, rgb_o=12'hFFF.
REQ-036 Tearing: change value to 16'h9999 mid-frame -> output unchanged until after the next frame_start pulse.
REQ-037 LZB: value=16'h0042 with NUMBER_RENDER_LZB_EN -> slots 0 and 1 hit_o=0; without it -> slot 0 address 0..99; value=16'h0000 with LZB -> only slot 3 renders.
REQ-038 Boundary/reset: pos_x=1000 -> no wrap hit at pixel_x<16; reset_n pulse mid-stream -> outputs 0 immediately, valid_o resumes 3 cycles after the next pix_valid.
